// File: rtl/pid_pkg.sv
// Shared widths, FSM state type and saturation limits for the PID sequencer.
package pid_pkg;

    localparam int unsigned PID_DW = 32;
    localparam int unsigned PID_KW = 8;
    localparam int unsigned PID_OW = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        OUT,
        FIN
    } pid_state_t;

    // Error-sum clamp limits for the default signal width.
    localparam logic signed [PID_DW-1:0] SAT_MAX = {1'b0, {(PID_DW-1){1'b1}}};
    localparam logic signed [PID_DW-1:0] SAT_MIN = {1'b1, {(PID_DW-1){1'b0}}};

endpackage

// File: rtl/pid_mac.sv
// Single-channel PID arithmetic: error, saturated error sum, Kp/Ki/Kd products and their sum.
module pid_mac
    import pid_pkg::*;
#(
    parameter int unsigned DW = PID_DW,
    parameter int unsigned KW = PID_KW,
    parameter int unsigned OW = PID_OW
) (
    input  logic signed [DW-1:0] tgt,
    input  logic signed [DW-1:0] sig,
    input  logic signed [DW-1:0] e,
    input  logic signed [DW-1:0] e1,
    input  logic signed [DW-1:0] sum_e,
    input  logic signed [KW-1:0] kp,
    input  logic signed [KW-1:0] ki,
    input  logic signed [KW-1:0] kd,
    output logic signed [DW-1:0] err,
    output logic signed [DW-1:0] sum_sat,
    output logic signed [OW-1:0] ctrl
);

    localparam logic signed [DW-1:0] LIM_HI = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] LIM_LO = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW:0]   sum_wide;
    logic signed [OW-1:0] pterm, iterm, dterm;

    // Error with DW-bit wrap, clamped running sum, and the OW-bit control value.
    always_comb begin
        err      = tgt - sig;
        sum_wide = (DW+1)'(sum_e) + (DW+1)'(e);
        if (sum_wide[DW] != sum_wide[DW-1]) begin
            sum_sat = sum_wide[DW] ? LIM_LO : LIM_HI;
        end else begin
            sum_sat = sum_wide[DW-1:0];
        end
        pterm = OW'(kp) * OW'(e);
        iterm = OW'(ki) * OW'(sum_sat);
        dterm = OW'(kd) * (OW'(e) - OW'(e1));
        ctrl  = pterm + iterm + dterm;
    end

endmodule

// File: rtl/pid_sched.sv
// Time-multiplexed PID sequencer: one pid_mac shared across NCH channels per sample tick.
module pid_sched
    import pid_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = PID_DW,
    parameter int unsigned KW  = PID_KW,
    parameter int unsigned OW  = PID_OW
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tick,
    input  logic [NCH-1:0]         en_mask,
    input  logic                   clr_state,
    input  logic [NCH*DW-1:0]      sig_in,
    input  logic [NCH*DW-1:0]      target,
    input  logic [NCH*KW-1:0]      kp,
    input  logic [NCH*KW-1:0]      ki,
    input  logic [NCH*KW-1:0]      kd,
    output logic [OW-1:0]          ctrl_out,
    output logic [$clog2(NCH)-1:0] ctrl_ch,
    output logic                   ctrl_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned CW = $clog2(NCH);

    pid_state_t state, next_state;

    logic [CW-1:0]        ch_r, first_ch, next_ch;
    logic                 first_found, next_found;
    logic [NCH-1:0]       en_snap;
    logic [NCH*DW-1:0]    sig_snap, tgt_snap;
    logic signed [DW-1:0] e_r;
    logic signed [KW-1:0] kp_r, ki_r, kd_r;
    logic signed [DW-1:0] e1_q  [NCH];
    logic signed [DW-1:0] sum_q [NCH];
    logic                 clr_pend;
    logic                 in_round, clr_now;
    logic signed [DW-1:0] mac_err, mac_sum;
    logic signed [OW-1:0] mac_ctrl;

    pid_mac #(.DW(DW), .KW(KW), .OW(OW)) u_mac (
        .tgt     (tgt_snap[32'(ch_r)*DW +: DW]),
        .sig     (sig_snap[32'(ch_r)*DW +: DW]),
        .e       (e_r),
        .e1      (e1_q[ch_r]),
        .sum_e   (sum_q[ch_r]),
        .kp      (kp_r),
        .ki      (ki_r),
        .kd      (kd_r),
        .err     (mac_err),
        .sum_sat (mac_sum),
        .ctrl    (mac_ctrl)
    );

    // Lowest enabled channel of the live mask, and next enabled snapshot channel above ch_r.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (en_mask[i-1]) begin
                first_found = 1'b1;
                first_ch    = CW'(i - 1);
            end
            if (en_snap[i-1] && (i - 1) > 32'(ch_r)) begin
                next_found = 1'b1;
                next_ch    = CW'(i - 1);
            end
        end
    end

    // Round sequencing: LOAD/CALC/OUT per enabled channel, then a single FIN cycle.
    always_comb begin
        next_state = state;
        in_round   = (state == LOAD) || (state == CALC) || (state == OUT);
        clr_now    = (state == IDLE && clr_state) || (state == FIN && (clr_pend || clr_state));
        case (state)
            IDLE:    if (tick) next_state = first_found ? LOAD : FIN;
            LOAD:    next_state = CALC;
            CALC:    next_state = OUT;
            OUT:     next_state = next_found ? LOAD : FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Snapshots, operand latches, history commit and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_out   <= '0;
            ctrl_ch    <= '0;
            ctrl_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            ch_r       <= '0;
            en_snap    <= '0;
            sig_snap   <= '0;
            tgt_snap   <= '0;
            e_r        <= '0;
            kp_r       <= '0;
            ki_r       <= '0;
            kd_r       <= '0;
            clr_pend   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                e1_q[i]  <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            ctrl_valid <= 1'b0;
            busy       <= (next_state == LOAD) || (next_state == CALC) || (next_state == OUT);
            done       <= (next_state == FIN);
            case (state)
                IDLE: if (tick) begin
                    en_snap  <= en_mask;
                    sig_snap <= sig_in;
                    tgt_snap <= target;
                    ch_r     <= first_ch;
                end
                LOAD: begin
                    e_r  <= mac_err;
                    kp_r <= kp[32'(ch_r)*KW +: KW];
                    ki_r <= ki[32'(ch_r)*KW +: KW];
                    kd_r <= kd[32'(ch_r)*KW +: KW];
                end
                CALC: begin
                    ctrl_out   <= mac_ctrl;
                    ctrl_ch    <= ch_r;
                    ctrl_valid <= 1'b1;
                end
                OUT: begin
                    e1_q[ch_r]  <= e_r;
                    sum_q[ch_r] <= mac_sum;
                    if (next_found) ch_r <= next_ch;
                end
                default: ;
            endcase
            // A clear requested mid-round waits for FIN so the round's commits are not torn.
            if (clr_now) begin
                clr_pend <= 1'b0;
                for (int unsigned i = 0; i < NCH; i++) begin
                    e1_q[i]  <= '0;
                    sum_q[i] <= '0;
                end
            end else if (clr_state && in_round) begin
                clr_pend <= 1'b1;
            end
            if (tick && in_round)  overrun <= 1'b1;
            else if (clr_state)    overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pid_sched.sv
// Randomised scoreboard bench for pid_sched against a per-channel arithmetic model.
module tb_pid_sched;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int KW  = 8;
    localparam int OW  = 64;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 tick = 1'b0;
    logic [NCH-1:0]       en_mask = '0;
    logic                 clr_state = 1'b0;
    logic [NCH*DW-1:0]    sig_in = '0;
    logic [NCH*DW-1:0]    target = '0;
    logic [NCH*KW-1:0]    kp = '0;
    logic [NCH*KW-1:0]    ki = '0;
    logic [NCH*KW-1:0]    kd = '0;
    logic [OW-1:0]        ctrl_out;
    logic [1:0]           ctrl_ch;
    logic                 ctrl_valid;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    int errors = 0;
    int checks = 0;

    longint m_e1  [NCH];
    longint m_sum [NCH];
    bit     exp_overrun = 1'b0;
    int     exp_ch  [$];
    longint exp_out [$];

    pid_sched #(.NCH(NCH), .DW(DW), .KW(KW), .OW(OW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick       (tick),
        .en_mask    (en_mask),
        .clr_state  (clr_state),
        .sig_in     (sig_in),
        .target     (target),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .ctrl_out   (ctrl_out),
        .ctrl_ch    (ctrl_ch),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_e1[c]  = 0;
            m_sum[c] = 0;
        end
    endtask

    // Expected strobes for one round, computed from the control law on plain integers.
    task automatic model_round(input logic [NCH-1:0] mask, input bit clr_first);
        logic [31:0] ew;
        longint e, s, o, gp, gi, gd;
        if (clr_first) model_clear();
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                ew = target[c*DW +: DW] - sig_in[c*DW +: DW];
                e  = longint'($signed(ew));
                s  = m_sum[c] + e;
                if (s > SMAX) s = SMAX;
                if (s < SMIN) s = SMIN;
                gp = longint'($signed(kp[c*KW +: KW]));
                gi = longint'($signed(ki[c*KW +: KW]));
                gd = longint'($signed(kd[c*KW +: KW]));
                o  = gp * e + gi * s + gd * (e - m_e1[c]);
                exp_ch.push_back(c);
                exp_out.push_back(o);
                m_e1[c]  = e;
                m_sum[c] = s;
            end
        end
    endtask

    task automatic set_ch(input int c, input logic [31:0] t, input logic [31:0] s,
                          input logic [7:0] p, input logic [7:0] i, input logic [7:0] d);
        target[c*DW +: DW] = t;
        sig_in[c*DW +: DW] = s;
        kp[c*KW +: KW] = p;
        ki[c*KW +: KW] = i;
        kd[c*KW +: KW] = d;
    endtask

    // One round; ovr_at / clr_at give the edge (after T) at which an extra tick / clear is sampled.
    task automatic run_round(input logic [NCH-1:0] mask, input bit clr, input int ovr_at, input int clr_at);
        int n;
        logic busy_first;
        model_round(mask, clr);
        if (clr) exp_overrun = 1'b0;
        if (ovr_at != 0) exp_overrun = 1'b1;
        if (clr_at != 0) exp_overrun = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1; en_mask = mask; clr_state = clr;
        @(posedge clk); #1;
        tick = 1'b0; clr_state = 1'b0;
        busy_first = busy;
        n = 1;
        while (!done && n < 64) begin
            if (ovr_at != 0 && n == ovr_at - 1) tick = 1'b1;
            if (clr_at != 0 && n == clr_at - 1) clr_state = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0; clr_state = 1'b0;
            n++;
        end
        if (clr_at != 0) model_clear();
        check("done_latency", n, 3 * $countones(mask) + 1);
        check("busy_at_T1", busy_first, (mask != 0) ? 1 : 0);
        check("busy_at_done", busy, 0);
        check("overrun", overrun, exp_overrun);
        check("strobes_consumed", exp_ch.size(), 0);
    endtask

    // Scoreboard monitor: every ctrl_valid must match the oldest expected strobe.
    always @(negedge clk) begin
        if (rstn && ctrl_valid) begin
            if (exp_ch.size() == 0) begin
                check("unexpected_strobe_ch", ctrl_ch, -1);
            end else begin
                check("ctrl_ch", ctrl_ch, exp_ch.pop_front());
                check("ctrl_out", $signed(ctrl_out), exp_out.pop_front());
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl_out"}, $signed(ctrl_out), 0);
        check({tag, "_ctrl_ch"}, ctrl_ch, 0);
        check({tag, "_ctrl_valid"}, ctrl_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        model_clear();
        for (int c = 0; c < NCH; c++) set_ch(c, $urandom, $urandom, $urandom, $urandom, $urandom);
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        rstn = 1'b1;

        // Basic P+I on channel 0.
        for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 0, 0, 0);
        set_ch(0, 100, 40, 2, 1, 0);
        run_round(4'b0001, 1'b0, 0, 0);
        run_round(4'b0001, 1'b0, 0, 0);

        // Derivative term with a changing feedback value.
        set_ch(0, 100, 40, 2, 1, 1);
        run_round(4'b0001, 1'b1, 0, 0);
        set_ch(0, 100, 50, 2, 1, 1);
        run_round(4'b0001, 1'b0, 0, 0);

        // Zero mask with clear, then a sparse mask, then the complementary mask.
        run_round(4'b0000, 1'b1, 0, 0);
        set_ch(0, 7, 3, 1, 1, 1);
        set_ch(1, -5, 20, 3, -2, 4);
        set_ch(2, 1000, -1000, -1, 2, -3);
        set_ch(3, 12345, 345, 5, 6, 7);
        run_round(4'b1010, 1'b0, 0, 0);
        run_round(4'b0101, 1'b0, 0, 0);
        run_round(4'b1111, 1'b0, 0, 0);

        // Error sum pinned at the positive limit.
        set_ch(0, 32'h7FFF_FFFF, 0, 0, 1, 0);
        for (int r = 0; r < 4; r++) run_round(4'b0001, r == 0, 0, 0);
        set_ch(0, 32'h8000_0000, 1, 0, 1, 0);
        for (int r = 0; r < 3; r++) run_round(4'b0001, 1'b0, 0, 0);

        // Tick while busy is ignored and overrun sticks.
        set_ch(0, 100, 40, 2, 1, 1);
        run_round(4'b0001, 1'b0, 2, 0);
        run_round(4'b0001, 1'b0, 0, 0);

        // Reset in the middle of a round.
        @(posedge clk); #1 tick = 1'b1; en_mask = 4'b0001;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 check_zero_outputs("midreset");
        rstn = 1'b1;
        model_clear();
        exp_overrun = 1'b0;
        run_round(4'b0001, 1'b0, 0, 0);

        // Clear while busy takes effect after the round's commits.
        set_ch(1, 300, 100, 1, 2, 3);
        run_round(4'b0011, 1'b0, 0, 0);
        run_round(4'b0011, 1'b0, 0, 2);
        run_round(4'b0011, 1'b0, 0, 0);

        // Clear while idle drops overrun and history.
        run_round(4'b0001, 1'b0, 3, 0);
        @(posedge clk); #1 clr_state = 1'b1;
        @(posedge clk); #1 clr_state = 1'b0;
        model_clear();
        exp_overrun = 1'b0;
        check("overrun_after_clr", overrun, 0);
        set_ch(0, 100, 40, 2, 0, 0);
        run_round(4'b0001, 1'b0, 0, 0);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0)
                    set_ch(c, 32'h7FFF_FFFF, 32'h8000_0000 + $urandom_range(0, 3), $urandom, $urandom, $urandom);
                else
                    set_ch(c, $urandom, $urandom, $urandom, $urandom, $urandom);
            end
            run_round(4'($urandom), $urandom_range(0, 7) == 0, 0, 0);
        end

        repeat (4) @(posedge clk);
        check("final_queue_empty", exp_ch.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_sched.md
# pid_sched

Time-multiplexed multi-channel PID sequencer. It shares one PID arithmetic datapath (error, integral, difference, Kp/Ki/Kd MAC) between `NCH` control loops. On each sample `tick` it snapshots all channel inputs, then services the enabled channels in ascending index order. It keeps per-channel history (previous error, error sum) in internal registers. It sits between the sensor/target capture logic and the actuator drivers, and replaces per-channel PID instances.

## Interface
- `NCH`, default 4: number of channels (2..16)
- `DW`, default 32: signal/target/error width, signed
- `KW`, default 8: gain width, signed
- `OW`, default 64: control output width, signed
- `clk`  in  1  system clock (50 MHz)
- `rstn`  in  1  reset; one clock, synchronous, active-low
- `tick`  in  1  sample strobe; starts one round
- `en_mask`  in  NCH  channel enables, sampled at accepted tick
- `clr_state`  in  1  zero all channel history (e1, sum_e)
- `sig_in`  in  NCH*DW  packed feedback, channel i at [i*DW +: DW]
- `target`  in  NCH*DW  packed setpoints, same packing
- `kp`, `ki`, `kd`  in  NCH*KW each  packed per-channel gains, sampled in the channel's LOAD cycle
- `ctrl_out`  out  OW  control value of channel `ctrl_ch`
- `ctrl_ch`  out  $clog2(NCH)  channel index of `ctrl_out`
- `ctrl_valid`  out  1  one-cycle strobe, `ctrl_out`/`ctrl_ch` valid
- `busy`  out  1  round in progress
- `done`  out  1  one-cycle strobe, round complete
- `overrun`  out  1  sticky: tick arrived while busy

## Operation
- FSM states: IDLE, LOAD, CALC, OUT, FIN.
- IDLE + tick: snapshot `sig_in`/`target`/`en_mask`. Go to LOAD at the lowest enabled channel, or to FIN if the mask is zero.
- LOAD: e = target − sig_in, DW-bit two's-complement wrap. Gains are latched.
- CALC: pterm = kp·e; iterm = ki·sat(sum_e + e); dterm = kd·(e − e1). All operands are sign-extended to OW before multiplying.
- OUT: ctrl_out = pterm + iterm + dterm, with OW-bit wrap. Assert ctrl_valid. Commit e1 ← e and sum_e ← sat(sum_e + e). Go to LOAD at the next enabled channel, or to FIN if none remain.
- FIN: pulse done, drop busy, return to IDLE.
- sat() clamps to [−2^(DW−1), 2^(DW−1)−1].
- Disabled channels cost zero cycles, and their history is untouched.
- tick while busy: ignored and overrun set. overrun clears only on clr_state or reset.
- clr_state in IDLE: history is zeroed in that cycle. clr_state together with tick: clear first, then the round runs on zero history. clr_state while busy: held pending and applied in FIN after the last commit.
- Reset (including mid-round): FSM → IDLE. ctrl_out = 0, ctrl_ch = 0, ctrl_valid = 0, busy = 0, done = 0, overrun = 0, all e1/sum_e = 0, snapshots = 0. No partial commit survives.

## Timing
- tick sampled at edge T. busy = 1 from T+1.
- First channel: LOAD in cycle T+1, CALC in T+2, OUT with ctrl_valid in T+3.
- Each further enabled channel adds 3 cycles.
- done is high and busy is low in cycle T+3k+1, where k = number of enabled channels. With a zero mask, done is at T+1 and no ctrl_valid occurs.
- The earliest accepted next tick is in the cycle after done (T+3k+2).
- All outputs are registered. ctrl_out/ctrl_ch hold their last value between strobes.

## Structure
- Package `pid_pkg` holds: the width localparams (DW, KW, OW defaults), the FSM state enum `pid_state_t`, and the SAT_MAX/SAT_MIN constants.
- Sub-module `pid_mac`: combinational/registered single-channel arithmetic covering error, saturation and the three products plus the sum. pid_sched owns the FSM, snapshots, history register file and channel selection.

## Test plan
- NCH=4, en=0001, kp=2, ki=1, kd=0, target=100, sig=40 → tick at T gives ctrl_valid at T+3, ch=0, ctrl_out=180. A second tick with the same inputs gives 240.
- Same setup with kd=1, sig changing from 40 to 50 between rounds → round 2: e=50, sum=110, ctrl_out = 100 + 110 − 10 = 200.
- en=1010, all channels active → strobes at T+3 (ch1) and T+6 (ch3). done at T+7. ch0/ch2 history stays 0.
- ki=1, e=0x7FFFFFFF on every tick → sum_e saturates at 0x7FFFFFFF from round 2 and never wraps negative.
- tick at T+2 during a 1-channel round → ignored, overrun=1 and sticky. clr_state in IDLE → overrun=0, history zero, next ctrl_out = kp·e only.
- rstn low at T+2 mid-round → next cycle all outputs are 0. The following round computes as if from fresh reset.
